muldiv_seq: RTL

Iterative signed multiply/divide unit for the multicycle CPU. It serves MIPS mult/div and feeds mfhi/mflo. The main control FSM issues a one-cycle start with operands A_Out/B_Out, then holds in a wait state while busy=1. On the done pulse the HI/LO results are valid and stay stable until the next accepted operation. The block raises a divide-by-zero flag for the exception logic (ExCause path).

---
 rtl/muldiv_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply and restoring
// divide on magnitudes, one step per clock, results held in HI/LO registers.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW    = 2 * WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t           state, state_next;
  logic             busy_next, done_next, div_zero_next;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    work;
  logic [WIDTH-1:0] mcand;
  logic             neg_q, neg_r;
  logic             last_step;

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] x);
    return n ? (~x + WIDTH'(1)) : x;
  endfunction

  // State and registered status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_next;
      busy     <= busy_next;
      done     <= done_next;
      div_zero <= div_zero_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!op)              state_next = S_MULT;
          else if (b_in == '0)  state_next = S_DONE;
          else                  state_next = S_DIV;
        end
      end
      S_MULT:  if (last_step) state_next = S_DONE;
      S_DIV:   if (last_step) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Flags are computed one cycle ahead so they come straight out of flops
  always_comb begin
    busy_next     = (state_next == S_MULT) || (state_next == S_DIV);
    done_next     = (state_next == S_DONE);
    div_zero_next = (state == S_IDLE) && start && op && (b_in == '0);
  end

  // Booth step: W+1-bit add keeps the most-negative multiplicand exact
  logic [WIDTH:0]   booth_sum;
  logic [PW-1:0]    booth_next;
  always_comb begin
    booth_sum = {work[PW-1], work[PW-1:WIDTH+1]};
    case (work[1:0])
      2'b01:   booth_sum = booth_sum + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = booth_sum - {mcand[WIDTH-1], mcand};
      default: booth_sum = {work[PW-1], work[PW-1:WIDTH+1]};
    endcase
    booth_next = {booth_sum, work[WIDTH:1]};
  end

  // Restoring divide step on magnitudes: remainder in upper half, quotient lower
  logic [WIDTH-1:0] div_rem, div_quo, rem_next, quo_next;
  logic [WIDTH:0]   div_shift, div_trial;
  always_comb begin
    div_rem   = work[2*WIDTH-1:WIDTH];
    div_quo   = work[WIDTH-1:0];
    div_shift = {div_rem, div_quo[WIDTH-1]};
    div_trial = div_shift - {1'b0, mcand};
    quo_next  = {div_quo[WIDTH-2:0], ~div_trial[WIDTH]};
    rem_next  = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work   <= '0;
      mcand  <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= '0;
            if (!op) begin
              mcand <= a_in;
              work  <= {WIDTH'(0), b_in, 1'b0};
            end else begin
              mcand <= mag(b_in);
              work  <= {1'b0, WIDTH'(0), mag(a_in)};
              neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              neg_r <= a_in[WIDTH-1];
            end
          end
        end
        S_MULT: begin
          work <= booth_next;
          cnt  <= cnt + CNT_W'(1);
          if (last_step) begin
            hi_out <= booth_next[PW-1:WIDTH+1];
            lo_out <= booth_next[WIDTH:1];
          end
        end
        S_DIV: begin
          work <= {1'b0, rem_next, quo_next};
          cnt  <= cnt + CNT_W'(1);
          // Sign fix-up: quotient truncates to zero, remainder follows dividend
          if (last_step) begin
            lo_out <= neg_if(neg_q, quo_next);
            hi_out <= neg_if(neg_r, rem_next);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
